// File: rtl/proc_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : proc_instr_sequencer
// Description : Program buffer of {instruction, expected writeback} pairs.
//               Issues the program on ir one entry per cycle, compares the
//               Proc writeback after RESULT_LAT cycles and counts pass/fail.
// Option      : PROC_SEQ_STALL_EN adds a 1-bit stall_i input that inserts
//               NOP bubbles while the program is being issued.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_instr_sequencer #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 16,
  parameter int RESULT_LAT = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            ld_valid_i,
  output logic            ld_ready_o,
  input  logic [XLEN-1:0] ld_instr_i,
  input  logic [XLEN-1:0] ld_expect_i,
  input  logic            start_i,
`ifdef PROC_SEQ_STALL_EN
  input  logic            stall_i,
`endif
  output logic [XLEN-1:0] ir_o,
  output logic            ir_valid_o,
  input  logic [XLEN-1:0] w_in_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [CW-1:0]   pass_cnt_o,
  output logic [CW-1:0]   fail_cnt_o,
  output logic [AW-1:0]   fail_idx_o
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
  localparam int              LW  = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;   // next entry to issue; equals count when all issued
  logic [LW-1:0]   drain_q, drain_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic            ir_valid_q, ir_valid_d;
  logic [XLEN-1:0] exp_q, exp_d;         // expectation travelling alongside ir
  logic [AW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   pass_q, pass_d;
  logic [CW-1:0]   fail_q, fail_d;
  logic [AW-1:0]   fidx_q, fidx_d;
  logic            ld_accept;
  logic            stall;

  logic [XLEN-1:0] mem_instr_q [DEPTH];
  logic [XLEN-1:0] mem_exp_q   [DEPTH];

  logic            pv_q [RESULT_LAT];
  logic [XLEN-1:0] pe_q [RESULT_LAT];
  logic [AW-1:0]   pi_q [RESULT_LAT];

`ifdef PROC_SEQ_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif

  // Next-state, issue and scoreboard logic
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    drain_d    = drain_q;
    ir_d       = NOP;
    ir_valid_d = 1'b0;
    exp_d      = exp_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    fidx_d     = fidx_q;
    ld_accept  = 1'b0;

    // Tail of the check pipe lines up with the writeback of that entry
    if (pv_q[RESULT_LAT-1]) begin
      if (w_in_i == pe_q[RESULT_LAT-1]) begin
        if (pass_q != '1) pass_d = pass_q + 1'b1;
      end else begin
        if (fail_q != '1) fail_d = fail_q + 1'b1;
        if (fail_q == '0) fidx_d = pi_q[RESULT_LAT-1];
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_IDLE) && ld_valid_i && (count_q < CW'(DEPTH))) begin
          ld_accept = 1'b1;
          count_d   = count_q + 1'b1;
        end
        if (start_i) begin
          pass_d = '0;
          fail_d = '0;
          fidx_d = '0;
          if (count_d != '0) begin
            state_d    = S_RUN;
            ir_valid_d = 1'b1;
            idx_d      = '0;
            rd_ptr_d   = CW'(1);
            // A load landing in the start cycle on an empty buffer is entry 0
            if (count_q == '0) begin
              ir_d  = ld_instr_i;
              exp_d = ld_expect_i;
            end else begin
              ir_d  = mem_instr_q[0];
              exp_d = mem_exp_q[0];
            end
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (rd_ptr_q == count_q) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else if (!stall) begin
          ir_d       = mem_instr_q[rd_ptr_q[AW-1:0]];
          exp_d      = mem_exp_q[rd_ptr_q[AW-1:0]];
          idx_d      = rd_ptr_q[AW-1:0];
          ir_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == LW'(RESULT_LAT - 1)) state_d = S_DONE;
        else                                drain_d = drain_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Datapath, pointer and counter registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      drain_q    <= '0;
      ir_q       <= NOP;
      ir_valid_q <= 1'b0;
      exp_q      <= '0;
      idx_q      <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      fidx_q     <= '0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      drain_q    <= drain_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      exp_q      <= exp_d;
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      fidx_q     <= fidx_d;
    end
  end

  // Program buffer write; contents are not reset
  always_ff @(posedge clk_i) begin
    if (ld_accept && !reset_i) begin
      mem_instr_q[count_q[AW-1:0]] <= ld_instr_i;
      mem_exp_q[count_q[AW-1:0]]   <= ld_expect_i;
    end
  end

  // Check pipe: delays {valid, expect, idx} of the issued entry by RESULT_LAT
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < RESULT_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pe_q[i] <= '0;
        pi_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= ir_valid_q;
      pe_q[0] <= exp_q;
      pi_q[0] <= idx_q;
      for (int i = 1; i < RESULT_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pi_q[i] <= pi_q[i-1];
      end
    end
  end

  assign ld_ready_o = (state_q == S_IDLE) && (count_q < CW'(DEPTH));
  assign ir_o       = ir_q;
  assign ir_valid_o = ir_valid_q;
  assign busy_o     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o     = (state_q == S_DONE);
  assign pass_cnt_o = pass_q;
  assign fail_cnt_o = fail_q;
  assign fail_idx_o = fidx_q;

endmodule
`default_nettype wire
